hazard_detect_unit: RTL and testbench



---
 rtl/hazard_pkg.sv | 10 +
 rtl/forward_select.sv | 18 +
 rtl/hazard_detect_unit.sv | 78 +++++++
 tb/tb_hazard_detect_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard detection and forwarding logic.
package hazard_pkg;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b01
    } fwd_sel_t;
endpackage

// File: rtl/forward_select.sv
// forward_select: picks the operand source for one EX-stage source register.
module forward_select
    import hazard_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd_addr,
    input  logic [REG_ADDR_W-1:0] mem_wb_rd_addr,
    input  logic                  ex_mem_reg_write,
    input  logic                  mem_wb_reg_write,
    output fwd_sel_t              sel
);
    logic mem_hit;
    logic wb_hit;
    assign mem_hit = ex_mem_reg_write && (ex_mem_rd_addr != REG_ZERO) && (ex_mem_rd_addr == rs_addr);
    assign wb_hit  = mem_wb_reg_write && (mem_wb_rd_addr != REG_ZERO) && (mem_wb_rd_addr == rs_addr);
    // The EX/MEM producer is younger, so it wins over MEM/WB.
    assign sel = mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: load-use stall detection, operand forwarding selects and stall statistics.
module hazard_detect_unit
    import hazard_pkg::*;
#(
    parameter int XLEN_REGS = 32,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_ex_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_ex_rs2_addr,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd_addr,
    input  logic [REG_ADDR_W-1:0] mem_wb_rd_addr,
    input  logic                  id_ex_mem_read,
    input  logic                  ex_mem_reg_write,
    input  logic                  mem_wb_reg_write,
    output logic                  stall,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  id_ex_flush,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall_q,
    output logic [CNT_W-1:0]      stall_count,
    output logic                  stall_count_sat
);
    if (XLEN_REGS > (1 << REG_ADDR_W)) begin : g_bad_regs
        $error("XLEN_REGS does not fit the register address width");
    end

    logic     hit1;
    logic     hit2;
    fwd_sel_t sel_a;
    fwd_sel_t sel_b;

    assign hit1 = (ex_mem_rd_addr != REG_ZERO) && (ex_mem_rd_addr == id_ex_rs1_addr);
    assign hit2 = (ex_mem_rd_addr != REG_ZERO) && (ex_mem_rd_addr == id_ex_rs2_addr);
    assign stall          = id_ex_mem_read && ex_mem_reg_write && (hit1 || hit2);
    assign pc_write_en    = ~stall;
    assign if_id_write_en = ~stall;
    assign id_ex_flush    = stall;

    forward_select u_fwd_a (
        .rs_addr          (id_ex_rs1_addr),
        .ex_mem_rd_addr   (ex_mem_rd_addr),
        .mem_wb_rd_addr   (mem_wb_rd_addr),
        .ex_mem_reg_write (ex_mem_reg_write),
        .mem_wb_reg_write (mem_wb_reg_write),
        .sel              (sel_a)
    );

    forward_select u_fwd_b (
        .rs_addr          (id_ex_rs2_addr),
        .ex_mem_rd_addr   (ex_mem_rd_addr),
        .mem_wb_rd_addr   (mem_wb_rd_addr),
        .ex_mem_reg_write (ex_mem_reg_write),
        .mem_wb_reg_write (mem_wb_reg_write),
        .sel              (sel_b)
    );

    assign forward_a = sel_a;
    assign forward_b = sel_b;

    // Counter holds at all-ones; the sticky flag marks the edge that would have wrapped it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q         <= 1'b0;
            stall_count     <= '0;
            stall_count_sat <= 1'b0;
        end else begin
            stall_q <= stall;
            if (stall) begin
                if (&stall_count) stall_count_sat <= 1'b1;
                else stall_count <= stall_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb_hazard_detect_unit: directed checks of stall, forwarding selects and the saturating stall counter.
module tb_hazard_detect_unit;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] rs1, rs2, exrd, wbrd;
    logic       mr, exw, wbw;
    logic       stall, pc_we, ifid_we, flush, stall_q, sat;
    logic [1:0] fa, fb;
    logic [1:0] cnt;
    int         passed = 0;
    int         total = 0;

    always #5 clk = ~clk;

    hazard_detect_unit #(.XLEN_REGS(32), .CNT_W(2)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .id_ex_rs1_addr   (rs1),
        .id_ex_rs2_addr   (rs2),
        .ex_mem_rd_addr   (exrd),
        .mem_wb_rd_addr   (wbrd),
        .id_ex_mem_read   (mr),
        .ex_mem_reg_write (exw),
        .mem_wb_reg_write (wbw),
        .stall            (stall),
        .pc_write_en      (pc_we),
        .if_id_write_en   (ifid_we),
        .id_ex_flush      (flush),
        .forward_a        (fa),
        .forward_b        (fb),
        .stall_q          (stall_q),
        .stall_count      (cnt),
        .stall_count_sat  (sat)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [4:0] a, b, e, w, input logic m, ew, ww);
        rs1 = a; rs2 = b; exrd = e; wbrd = w; mr = m; exw = ew; wbw = ww;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) edge_step();
        chk("rst_stall_q", {7'd0, stall_q}, 8'd0);
        chk("rst_count", {6'd0, cnt}, 8'd0);
        chk("rst_sat", {7'd0, sat}, 8'd0);
        reset_n = 1'b1;
        edge_step();
        chk("idle_count", {6'd0, cnt}, 8'd0);

        drive(5'd1, 5'd2, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1);
        chk("lu_stall", {7'd0, stall}, 8'd1);
        chk("lu_pc_we", {7'd0, pc_we}, 8'd0);
        chk("lu_ifid_we", {7'd0, ifid_we}, 8'd0);
        chk("lu_flush", {7'd0, flush}, 8'd1);
        chk("lu_fa", {6'd0, fa}, 8'h2);
        chk("lu_fb", {6'd0, fb}, 8'h0);
        edge_step();
        chk("lu_stall_q", {7'd0, stall_q}, 8'd1);
        chk("lu_count", {6'd0, cnt}, 8'd1);

        drive(5'd1, 5'd2, 5'd1, 5'd4, 1'b0, 1'b1, 1'b1);
        chk("nold_stall", {7'd0, stall}, 8'd0);
        chk("nold_fa", {6'd0, fa}, 8'h2);
        chk("nold_pc_we", {7'd0, pc_we}, 8'd1);
        edge_step();
        chk("nold_stall_q", {7'd0, stall_q}, 8'd0);
        chk("nold_count", {6'd0, cnt}, 8'd1);

        drive(5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        chk("x0_stall", {7'd0, stall}, 8'd0);
        chk("x0_fa", {6'd0, fa}, 8'h0);
        chk("x0_fb", {6'd0, fb}, 8'h0);

        drive(5'd0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1);
        chk("prio_fb", {6'd0, fb}, 8'h2);
        chk("prio_fa", {6'd0, fa}, 8'h0);
        drive(5'd0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1);
        chk("wb_fb", {6'd0, fb}, 8'h1);
        drive(5'd4, 5'd2, 5'd5, 5'd4, 1'b1, 1'b1, 1'b1);
        chk("wb_fa", {6'd0, fa}, 8'h1);
        chk("wb_nostall", {7'd0, stall}, 8'd0);
        drive(5'd3, 5'd7, 5'd7, 5'd3, 1'b1, 1'b1, 1'b0);
        chk("rs2_stall", {7'd0, stall}, 8'd1);
        chk("rs2_fa_wbw0", {6'd0, fa}, 8'h0);

        reset_n = 1'b0;
        #1;
        chk("mid_rst_count", {6'd0, cnt}, 8'd0);
        reset_n = 1'b1;
        edge_step();
        chk("sat_c1", {6'd0, cnt}, 8'd1);
        chk("sat_f1", {7'd0, sat}, 8'd0);
        edge_step();
        chk("sat_c2", {6'd0, cnt}, 8'd2);
        edge_step();
        chk("sat_c3", {6'd0, cnt}, 8'd3);
        chk("sat_f3", {7'd0, sat}, 8'd0);
        edge_step();
        chk("sat_c4", {6'd0, cnt}, 8'd3);
        chk("sat_f4", {7'd0, sat}, 8'd1);
        edge_step();
        chk("sat_sticky", {7'd0, sat}, 8'd1);

        #2;
        reset_n = 1'b0;
        #1;
        chk("async_count", {6'd0, cnt}, 8'd0);
        chk("async_sat", {7'd0, sat}, 8'd0);
        chk("async_stall_q", {7'd0, stall_q}, 8'd0);
        chk("rst_comb_stall", {7'd0, stall}, 8'd1);
        edge_step();
        chk("rst_wins_count", {6'd0, cnt}, 8'd0);
        reset_n = 1'b1;
        edge_step();
        chk("post_rst_count", {6'd0, cnt}, 8'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
